// File: rtl/vliw_pipe_pkg.sv
// vliw_pipe_pkg: shared widths, per-slot control record and counter helpers for the VLIW ID/EX pipe.
package vliw_pipe_pkg;
    localparam int NSLOT   = 2;
    localparam int REG_AW  = 3;
    localparam int DATA_W  = 16;
    localparam int FUNCT_W = 3;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic               valid;
        logic               memread;
        logic               memwrite;
        logic               regwrite;
        logic [REG_AW-1:0]  regdest;
        logic [FUNCT_W-1:0] funct;
    } slot_ctrl_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
        return (en && c != CNT_MAX) ? c + 16'd1 : c;
    endfunction
endpackage

// File: rtl/vliw_id_ex_pipe_if.sv
// vliw_id_ex_pipe_if: decode-side inputs, hazard-unit controls and stage/hazard outputs of the dual-slot pipe.
interface vliw_id_ex_pipe_if;
    import vliw_pipe_pkg::*;
    logic [NSLOT-1:0]         id_valid, id_memread, id_memwrite, id_regwrite;
    logic [NSLOT*REG_AW-1:0]  id_regdest;
    logic [NSLOT*FUNCT_W-1:0] id_funct;
    logic [NSLOT*DATA_W-1:0]  id_opa, id_opb;
    logic                     bubble, flush, hold;
    logic [NSLOT*DATA_W-1:0]  ex_result;
    logic [NSLOT-1:0]         ex_valid, ex_memread, ex_memwrite, ex_regwrite;
    logic [NSLOT*REG_AW-1:0]  ex_regdest;
    logic [NSLOT*FUNCT_W-1:0] ex_funct;
    logic [NSLOT*DATA_W-1:0]  ex_opa, ex_opb;
    logic [NSLOT-1:0]         mem_valid, mem_memread, mem_memwrite, mem_regwrite;
    logic [NSLOT*REG_AW-1:0]  mem_regdest;
    logic [NSLOT*DATA_W-1:0]  mem_result;
    logic [NSLOT-1:0]         p1_memread, p1_regwrite, p2_memread, p2_regwrite;
    logic [NSLOT*REG_AW-1:0]  p1_regdest, p2_regdest;
    logic [15:0]              bubble_cnt, flush_cnt, hold_cnt;

    modport master (
        output id_valid, id_memread, id_memwrite, id_regwrite, id_regdest, id_funct, id_opa, id_opb,
        output bubble, flush, hold, ex_result,
        input  ex_valid, ex_memread, ex_memwrite, ex_regwrite, ex_regdest, ex_funct, ex_opa, ex_opb,
        input  mem_valid, mem_memread, mem_memwrite, mem_regwrite, mem_regdest, mem_result,
        input  p1_memread, p1_regwrite, p1_regdest, p2_memread, p2_regwrite, p2_regdest,
        input  bubble_cnt, flush_cnt, hold_cnt
    );
    modport slave (
        input  id_valid, id_memread, id_memwrite, id_regwrite, id_regdest, id_funct, id_opa, id_opb,
        input  bubble, flush, hold, ex_result,
        output ex_valid, ex_memread, ex_memwrite, ex_regwrite, ex_regdest, ex_funct, ex_opa, ex_opb,
        output mem_valid, mem_memread, mem_memwrite, mem_regwrite, mem_regdest, mem_result,
        output p1_memread, p1_regwrite, p1_regdest, p2_memread, p2_regwrite, p2_regdest,
        output bubble_cnt, flush_cnt, hold_cnt
    );
endinterface

// File: rtl/vliw_slot_reg.sv
// vliw_slot_reg: one slot's ID/EX and EX/MEM registers with flush > hold > bubble priority.
module vliw_slot_reg
    import vliw_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  slot_ctrl_t        id_ctrl,
    input  logic [DATA_W-1:0] id_opa,
    input  logic [DATA_W-1:0] id_opb,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              bubble,
    input  logic              flush,
    input  logic              hold,
    output slot_ctrl_t        ex_ctrl,
    output logic [DATA_W-1:0] ex_opa,
    output logic [DATA_W-1:0] ex_opb,
    output logic              mem_valid,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic              mem_regwrite,
    output logic [REG_AW-1:0] mem_regdest,
    output logic [DATA_W-1:0] mem_result
);
    logic ex_clr, mem_clr;
    assign ex_clr  = flush || (bubble && !hold);
    assign mem_clr = flush || hold;

    // An invalid slot is loaded as all zeros, so it is indistinguishable from a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl    <= '0;
            ex_opa     <= '0;
            ex_opb     <= '0;
            {mem_valid, mem_memread, mem_memwrite, mem_regwrite, mem_regdest, mem_result} <= '0;
        end else begin
            if (ex_clr) begin
                ex_ctrl <= '0;
                ex_opa  <= '0;
                ex_opb  <= '0;
            end else if (!hold) begin
                ex_ctrl <= id_ctrl.valid ? id_ctrl : '0;
                ex_opa  <= id_ctrl.valid ? id_opa : '0;
                ex_opb  <= id_ctrl.valid ? id_opb : '0;
            end
            if (mem_clr)
                {mem_valid, mem_memread, mem_memwrite, mem_regwrite, mem_regdest, mem_result} <= '0;
            else begin
                {mem_valid, mem_memread, mem_memwrite, mem_regwrite, mem_regdest} <=
                    {ex_ctrl.valid, ex_ctrl.memread, ex_ctrl.memwrite, ex_ctrl.regwrite, ex_ctrl.regdest};
                mem_result <= ex_result;
            end
        end
    end
endmodule

// File: rtl/vliw_id_ex_pipe.sv
// vliw_id_ex_pipe: dual-slot ID/EX + EX/MEM pipeline registers feeding hazard info back to the hazard unit.
// Define VLIW_PIPE_PERF_CNT_EN to build the saturating bubble/flush/hold counters.
module vliw_id_ex_pipe
    import vliw_pipe_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    vliw_id_ex_pipe_if.slave  bus
);
    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        slot_ctrl_t        id_ctrl, ex_ctrl;
        logic [DATA_W-1:0] ex_opa, ex_opb, mem_result;
        logic              mem_valid, mem_memread, mem_memwrite, mem_regwrite;
        logic [REG_AW-1:0] mem_regdest;
        assign id_ctrl = '{valid: bus.id_valid[i], memread: bus.id_memread[i],
                           memwrite: bus.id_memwrite[i], regwrite: bus.id_regwrite[i],
                           regdest: bus.id_regdest[i*REG_AW +: REG_AW],
                           funct: bus.id_funct[i*FUNCT_W +: FUNCT_W]};
        vliw_slot_reg u_slot (
            .clk, .rst_n, .id_ctrl,
            .id_opa(bus.id_opa[i*DATA_W +: DATA_W]),
            .id_opb(bus.id_opb[i*DATA_W +: DATA_W]),
            .ex_result(bus.ex_result[i*DATA_W +: DATA_W]),
            .bubble(bus.bubble), .flush(bus.flush), .hold(bus.hold),
            .ex_ctrl, .ex_opa, .ex_opb,
            .mem_valid, .mem_memread, .mem_memwrite, .mem_regwrite, .mem_regdest, .mem_result
        );
        assign bus.ex_valid[i]                       = ex_ctrl.valid;
        assign bus.ex_memread[i]                     = ex_ctrl.memread;
        assign bus.ex_memwrite[i]                    = ex_ctrl.memwrite;
        assign bus.ex_regwrite[i]                    = ex_ctrl.regwrite;
        assign bus.ex_regdest[i*REG_AW +: REG_AW]    = ex_ctrl.regdest;
        assign bus.ex_funct[i*FUNCT_W +: FUNCT_W]    = ex_ctrl.funct;
        assign bus.ex_opa[i*DATA_W +: DATA_W]        = ex_opa;
        assign bus.ex_opb[i*DATA_W +: DATA_W]        = ex_opb;
        assign bus.mem_valid[i]                      = mem_valid;
        assign bus.mem_memread[i]                    = mem_memread;
        assign bus.mem_memwrite[i]                   = mem_memwrite;
        assign bus.mem_regwrite[i]                   = mem_regwrite;
        assign bus.mem_regdest[i*REG_AW +: REG_AW]   = mem_regdest;
        assign bus.mem_result[i*DATA_W +: DATA_W]    = mem_result;
    end

    assign bus.p1_memread  = bus.ex_memread;
    assign bus.p1_regwrite = bus.ex_regwrite;
    assign bus.p1_regdest  = bus.ex_regdest;
    assign bus.p2_memread  = bus.mem_memread;
    assign bus.p2_regwrite = bus.mem_regwrite;
    assign bus.p2_regdest  = bus.mem_regdest;

`ifdef VLIW_PIPE_PERF_CNT_EN
    logic [15:0] bubble_q, flush_q, hold_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_q <= '0;
            flush_q  <= '0;
            hold_q   <= '0;
        end else begin
            bubble_q <= sat_inc(bubble_q, bus.bubble && !bus.hold && !bus.flush);
            flush_q  <= sat_inc(flush_q, bus.flush);
            hold_q   <= sat_inc(hold_q, bus.hold);
        end
    end
    assign bus.bubble_cnt = bubble_q;
    assign bus.flush_cnt  = flush_q;
    assign bus.hold_cnt   = hold_q;
`else
    assign bus.bubble_cnt = '0;
    assign bus.flush_cnt  = '0;
    assign bus.hold_cnt   = '0;
`endif
endmodule

// File: doc/vliw_id_ex_pipe.md
Name: vliw_id_ex_pipe

Overview:
Dual-slot ID/EX and EX/MEM pipeline registers for the 2-wide VLIW core. This block receives the stall and bubble decisions from the hazard detection unit.
- Applies bubble, flush and hold to both slots.
- Returns registered EX-stage (p1_*) and MEM-stage (p2_*) destination and control info to the hazard unit, closing the hazard loop.
- Sits between decode and the ALU/memory stages.

Parameters:
REG_AW, 3, register-address width (8 architectural registers)
DATA_W, 16, operand/result width per slot
FUNCT_W, 3, funct field width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  2  per-slot decoded instruction valid
id_memread  in  2  per-slot load
id_memwrite  in  2  per-slot store
id_regwrite  in  2  per-slot register writeback
id_regdest  in  2*REG_AW  per-slot destination register
id_funct  in  2*FUNCT_W  per-slot funct
id_opa  in  2*DATA_W  per-slot operand A
id_opb  in  2*DATA_W  per-slot operand B
bubble  in  1  from hazard unit (id_ex_controlvalue): insert bubble into ID/EX
flush  in  1  branch taken: kill ID/EX contents
hold  in  1  EX multicycle busy: freeze ID/EX
ex_result  in  2*DATA_W  per-slot ALU result for EX/MEM capture
ex_valid, ex_memread, ex_memwrite, ex_regwrite  out  2 each  ID/EX controls
ex_regdest  out  2*REG_AW; ex_funct  out  2*FUNCT_W; ex_opa, ex_opb  out  2*DATA_W
mem_valid, mem_memread, mem_memwrite, mem_regwrite  out  2 each  EX/MEM controls
mem_regdest  out  2*REG_AW; mem_result  out  2*DATA_W
p1_memread, p1_regwrite  out  2 each; p1_regdest  out  2*REG_AW  EX-stage hazard info
p2_memread, p2_regwrite  out  2 each; p2_regdest  out  2*REG_AW  MEM-stage hazard info
bubble_cnt, flush_cnt, hold_cnt  out  16 each  performance counters

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0, counters included. Deassertion is synchronous to clk.
- Per slot i, all controls are loaded as id_x[i] & id_valid[i]. An invalid slot never carries live controls.
- ID/EX update priority on each rising clk edge:
  - flush: all ID/EX fields cleared to 0.
  - else hold: all ID/EX fields keep their value.
  - else bubble: all ID/EX fields cleared to 0.
  - else: load from id_*.
- EX/MEM update on each rising clk edge:
  - hold or flush: mem_* fields cleared to 0, so the MEM stage drains while EX is frozen or squashed.
  - else: mem controls and mem_regdest load from ex_*; mem_result loads from ex_result.
- A flushed instruction never reaches MEM. Flush and hold in the same cycle clear both stages.
- Latency: id_* to ex_* is 1 cycle; ex_* to mem_* is 1 cycle.
- Hazard outputs are pure wires from registers, with no added latency:
  - p1_* = ex_memread, ex_regwrite, ex_regdest.
  - p2_* = mem_memread, mem_regwrite, mem_regdest.
- Bubble applied with id_valid=0 is legal. The result is identical to a normal load of an empty slot.
- Slots are independent. There is no per-slot stall; bubble, flush and hold always act on both slots.

Optional Feature:
VLIW_PIPE_PERF_CNT_EN
- Defined: each counter increments by 1 in every cycle its signal is high.
  - bubble_cnt counts bubble accepted, i.e. bubble & !hold & !flush.
  - flush_cnt counts flush.
  - hold_cnt counts hold.
  - Counters saturate at 0xFFFF, with no wrap, and clear only on reset.
- Undefined: counter outputs are tied to 0 and no counter flops are built. Ports remain present.

Decomposition:
- Package vliw_pipe_pkg:
  - NSLOT=2, REG_AW, DATA_W, FUNCT_W.
  - Struct slot_ctrl_t holding {valid, memread, memwrite, regwrite, regdest, funct}.
  - CNT_MAX=16'hFFFF.
- Sub-module vliw_slot_reg: one slot's ID/EX and EX/MEM registers with the flush/hold/bubble logic. Instantiated twice.
- The counters live in the top level.

Test Plan:
1. Reset mid-stream: rst_n driven low while ex_valid=2'b11 -> ex_*, mem_* and counters read 0 immediately, without waiting for a clk edge.
2. Load flow: slot0 id_valid=1, memread=1, regwrite=1, regdest=3 at cycle 0.
   - Cycle 1: p1_memread[0]=1, p1_regdest[0]=3.
   - Cycle 2: p2_memread[0]=1, mem_result[0] equals ex_result[0] sampled at cycle 1.
3. Bubble one cycle with id_valid=2'b11, all controls 1 -> next cycle ex_valid=00, ex_regwrite=00, ex_regdest=0; the following cycle mem_valid=00.
4. Hold 3 cycles with ex_valid=2'b01 -> ex_* unchanged for 3 cycles, mem_valid=00 during hold, normal flow resumes on the cycle after hold drops.
5. Flush and hold in the same cycle -> ex_valid=00 and mem_valid=00 next cycle. Flush alone with bubble also high -> ID/EX cleared, bubble_cnt not incremented.
6. VLIW_PIPE_PERF_CNT_EN defined, bubble held for 70000 cycles -> bubble_cnt=0xFFFF, stays there. Macro undefined -> bubble_cnt=0 throughout.
